monster_scheduler: RTL
======================

Name: monster_scheduler

Overview:
- Game sequencer for the spaceship display.
- Decides when a monster appears in the top or bottom tunnel, and drives top_monster_ctrl / btm_monster_ctrl into the display controller.
- Times each monster's attack and asserts the shield-broken pulses.
- Tracks score and lives, and runs the IDLE / PLAY / OVER game state machine.

Parameters:
- SPAWN_TICKS, 120: game ticks between spawn attempts; legal range 1..1023.
- ATTACK_TICKS, 300: game ticks a live monster survives before breaking its lane's shield; legal range 1..1023.
- LIVES_INIT, 3: lives loaded when PLAY is entered; legal range 1..3.
- LFSR_SEED, 8'hA5: lane-select LFSR reset value; must be nonzero.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- tick  in  1  one-Clk-wide game-tick enable (slow pulse).
- start  in  1  one-Clk pulse (debounced BtnC).
- top_hit  in  1  one-Clk pulse: the top laser reached a live top monster.
- btm_hit  in  1  one-Clk pulse: the bottom laser reached a live bottom monster.
- top_monster_ctrl  out  1  top monster present.
- btm_monster_ctrl  out  1  bottom monster present.
- top_broken  out  1  one-Clk pulse: top shield broken.
- btm_broken  out  1  one-Clk pulse: bottom shield broken.
- score  out  8  monsters destroyed; saturates at 255.
- lives  out  2  remaining lives.
- game_over  out  1  high while in OVER.
- state  out  2  IDLE=0, PLAY=1, OVER=2.

Behaviour:
- Reset (Reset low, asynchronous):
  - state=IDLE; both ctrl, both broken, score, lives and game_over = 0.
  - spawn_cnt=0; both attack counters = 0; lfsr=LFSR_SEED.
- All other logic updates on rising Clk only.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4; advances every Clk in every state.
  - Lane select = lfsr[0]: 0 means top, 1 means bottom.
- FSM:
  - IDLE: outputs held at 0.
  - IDLE + start -> PLAY next cycle. On entry: lives=LIVES_INIT, score=0, spawn_cnt=0, both attack counters=0, both ctrl=0.
  - PLAY -> OVER in the cycle after lives becomes 0. On entry to OVER, both ctrl clear.
  - OVER: game_over=1; score and lives hold.
  - OVER + start -> IDLE. A start pulse in PLAY is ignored.
- Spawn (PLAY only, counts on tick):
  - On each tick, spawn_cnt increments.
  - When spawn_cnt==SPAWN_TICKS-1 on a tick, spawn_cnt clears to 0 and a spawn attempt happens in that same cycle.
  - The selected lane spawns if it is free; otherwise the other lane spawns if it is free; if both are occupied, nothing spawns.
  - Spawning sets that lane's ctrl=1 and clears its attack counter.
- Attack (per lane, PLAY only):
  - While ctrl=1, the lane's attack counter increments on each tick.
  - On the tick where the counter equals ATTACK_TICKS-1:
    - ctrl clears;
    - broken pulses high for exactly that one following Clk cycle;
    - lives decrements, saturating at 0.
- Hit:
  - A hit pulse with ctrl=1 clears ctrl and the attack counter, and score increments (saturating at 255).
  - A hit pulse with ctrl=0 is ignored; no score change.
- Simultaneous events:
  - Hit and attack expiry in the same cycle on the same lane: the hit wins; no broken pulse, no life lost.
  - Both lanes expire in the same cycle: lives decrements by 2, saturating at 0, and both broken pulses fire.
  - Both lanes hit in the same cycle: score increments by 2, saturating at 255.
  - A spawn attempt coinciding with a hit or expiry on the selected lane sees that lane as occupied, so the fallback rule applies.
  - Lives reaching 0 and a spawn attempt in the same cycle: the spawn is suppressed.
- tick low: no counter advances; hits are still processed.
- Reset asserted mid-game: everything returns to reset values immediately, regardless of Clk.
- Outputs are registered; ctrl and broken change one Clk after the causing event.

Test Plan (bench parameters SPAWN_TICKS=4, ATTACK_TICKS=8, LIVES_INIT=3, LFSR_SEED=8'hA5):
1. Reset low mid-PLAY with top_monster_ctrl=1 and score=5 -> all outputs 0 and state=0 with no Clk edge; lfsr reads 8'hA5.
2. start pulse, then 4 ticks -> state=1, lives=3; after the 4th tick exactly one ctrl=1, with the lane matching lfsr[0] at that cycle.
3. Monster spawned, no hits, 8 ticks -> its ctrl falls, that lane's broken is high for 1 Clk, lives=2; repeat twice more -> lives=0, then state=2 and game_over=1 the next cycle.
4. top_hit while top_monster_ctrl=1 -> ctrl=0 and score=1 next cycle; top_hit again while ctrl=0 -> score stays 1.
5. top_hit in the same cycle as the top expiry tick -> score increments, top_broken stays 0, lives unchanged; force both lanes to expire together with lives=3 -> lives=1 and both broken pulse.
6. Both lanes occupied at a spawn attempt -> no change, spawn_cnt back at 0; then score forced to 255 and a hit -> score stays 255.

Source files
------------

// File: rtl/monster_scheduler.sv
// ============================================================================
// Module   : monster_scheduler
// Purpose  : Spawns/attacks tunnel monsters, tracks score and lives, runs the
//            IDLE/PLAY/OVER game state machine for the spaceship display.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module monster_scheduler #(
  parameter int         SPAWN_TICKS  = 120,
  parameter int         ATTACK_TICKS = 300,
  parameter int         LIVES_INIT   = 3,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       tick,
  input  logic       start,
  input  logic       top_hit,
  input  logic       btm_hit,
  output logic       top_monster_ctrl,
  output logic       btm_monster_ctrl,
  output logic       top_broken,
  output logic       btm_broken,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       game_over,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } t_state;

  localparam logic [9:0] c_SPAWN_LAST  = 10'(SPAWN_TICKS - 1);
  localparam logic [9:0] c_ATTACK_LAST = 10'(ATTACK_TICKS - 1);
  localparam logic [1:0] c_LIVES_INIT  = 2'(LIVES_INIT);

  t_state     r_state;
  logic [7:0] r_lfsr;
  logic [9:0] r_spawn_cnt;
  logic [9:0] r_top_att;
  logic [9:0] r_btm_att;

  logic       w_top_hit, w_btm_hit;
  logic       w_top_exp, w_btm_exp;
  logic [1:0] w_lose, w_gain;
  logic [1:0] w_lives_nxt;
  logic [8:0] w_score_sum;
  logic [7:0] w_score_nxt;
  logic       w_attempt, w_spawn_ok;
  logic       w_spawn_top, w_spawn_btm;
  logic       w_fb;

  assign state = r_state;

  // A hit on a live monster beats an expiry landing in the same cycle.
  assign w_top_hit = top_hit & top_monster_ctrl;
  assign w_btm_hit = btm_hit & btm_monster_ctrl;
  assign w_top_exp = tick & top_monster_ctrl & (r_top_att == c_ATTACK_LAST) & ~w_top_hit;
  assign w_btm_exp = tick & btm_monster_ctrl & (r_btm_att == c_ATTACK_LAST) & ~w_btm_hit;

  assign w_lose      = {1'b0, w_top_exp} + {1'b0, w_btm_exp};
  assign w_gain      = {1'b0, w_top_hit} + {1'b0, w_btm_hit};
  assign w_lives_nxt = (lives > w_lose) ? (lives - w_lose) : 2'd0;
  assign w_score_sum = {1'b0, score} + {7'd0, w_gain};
  assign w_score_nxt = w_score_sum[8] ? 8'hFF : w_score_sum[7:0];

  // Lanes being hit or expiring this cycle still count as occupied.
  assign w_attempt   = tick & (r_spawn_cnt == c_SPAWN_LAST);
  assign w_spawn_ok  = w_attempt & (w_lives_nxt != 2'd0);
  assign w_spawn_top = w_spawn_ok & (r_lfsr[0] ? (btm_monster_ctrl & ~top_monster_ctrl)
                                               : ~top_monster_ctrl);
  assign w_spawn_btm = w_spawn_ok & (r_lfsr[0] ? ~btm_monster_ctrl
                                               : (top_monster_ctrl & ~btm_monster_ctrl));

  assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state          <= S_IDLE;
      r_lfsr           <= LFSR_SEED;
      r_spawn_cnt      <= '0;
      r_top_att        <= '0;
      r_btm_att        <= '0;
      top_monster_ctrl <= 1'b0;
      btm_monster_ctrl <= 1'b0;
      top_broken       <= 1'b0;
      btm_broken       <= 1'b0;
      score            <= '0;
      lives            <= '0;
      game_over        <= 1'b0;
    end else begin
      r_lfsr     <= {r_lfsr[6:0], w_fb};
      top_broken <= 1'b0;
      btm_broken <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state          <= S_PLAY;
            lives            <= c_LIVES_INIT;
            score            <= '0;
            r_spawn_cnt      <= '0;
            r_top_att        <= '0;
            r_btm_att        <= '0;
            top_monster_ctrl <= 1'b0;
            btm_monster_ctrl <= 1'b0;
          end
        end
        S_PLAY: begin
          if (lives == 2'd0) begin
            r_state          <= S_OVER;
            game_over        <= 1'b1;
            top_monster_ctrl <= 1'b0;
            btm_monster_ctrl <= 1'b0;
          end else begin
            lives      <= w_lives_nxt;
            score      <= w_score_nxt;
            top_broken <= w_top_exp;
            btm_broken <= w_btm_exp;
            if (tick)
              r_spawn_cnt <= (r_spawn_cnt == c_SPAWN_LAST) ? 10'd0 : r_spawn_cnt + 10'd1;

            if (w_spawn_top) begin
              top_monster_ctrl <= 1'b1;
              r_top_att        <= '0;
            end else if (w_top_hit || w_top_exp) begin
              top_monster_ctrl <= 1'b0;
              r_top_att        <= '0;
            end else if (tick && top_monster_ctrl) begin
              r_top_att <= r_top_att + 10'd1;
            end

            if (w_spawn_btm) begin
              btm_monster_ctrl <= 1'b1;
              r_btm_att        <= '0;
            end else if (w_btm_hit || w_btm_exp) begin
              btm_monster_ctrl <= 1'b0;
              r_btm_att        <= '0;
            end else if (tick && btm_monster_ctrl) begin
              r_btm_att <= r_btm_att + 10'd1;
            end
          end
        end
        S_OVER: begin
          if (start) begin
            r_state   <= S_IDLE;
            game_over <= 1'b0;
            score     <= '0;
            lives     <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
